// File: rtl/ysyx_23060203_alu_pkg.sv
// Shared ALU function codes and arbiter port count.
// Codes follow the RISC-V funct3 layout so decode can pass funct3 straight through.
package ysyx_23060203_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_LTS = 3'b010;
  localparam logic [2:0] ALU_LTU = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SHR = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam int ALU_ARB_PORTS = 2;

endpackage

// File: rtl/ysyx_23060203_alu_arb_alu.sv
// Purely combinational 32-bit ALU; funcs selects sub on ADD
// and arithmetic shift on SHR.
module ysyx_23060203_ALU
  import ysyx_23060203_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct,
  input  logic        funcs,
  output logic [31:0] val
);

  logic [4:0] shamt;

  assign shamt = b[4:0];

  always_comb begin
    val = 32'd0;
    unique case (funct)
      ALU_ADD: val = funcs ? a - b : a + b;
      ALU_SHL: val = a << shamt;
      ALU_LTS: val = {31'd0, $signed(a) < $signed(b)};
      ALU_LTU: val = {31'd0, a < b};
      ALU_XOR: val = a ^ b;
      ALU_SHR: val = funcs ? 32'($signed(a) >>> shamt)
                           : a >> shamt;
      ALU_OR:  val = a | b;
      ALU_AND: val = a & b;
      default: val = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060203_alu_arb.sv
// Two-port arbiter around one shared ALU with a one-entry result stage.
// Define ALU_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module ysyx_23060203_alu_arb
  import ysyx_23060203_alu_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ALU_ARB_PORTS-1:0]             req_valid,
  output logic [ALU_ARB_PORTS-1:0]             req_ready,
  input  logic [ALU_ARB_PORTS-1:0][31:0]       req_a,
  input  logic [ALU_ARB_PORTS-1:0][31:0]       req_b,
  input  logic [ALU_ARB_PORTS-1:0][2:0]        req_funct,
  input  logic [ALU_ARB_PORTS-1:0]             req_funcs,
  input  logic [ALU_ARB_PORTS-1:0][TAG_W-1:0]  req_tag,
  output logic [ALU_ARB_PORTS-1:0]             rsp_valid,
  input  logic [ALU_ARB_PORTS-1:0]             rsp_ready,
  output logic [31:0]                          rsp_data,
  output logic [TAG_W-1:0]                     rsp_tag
);

  logic             out_v;
  logic             out_owner;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  logic [1:0]  grant;
  logic        sel;
  logic        drain;
  logic        free;
  logic        fire;
  logic [31:0] alu_val;
  logic        conflict_pick;

`ifdef ALU_ARB_RR_EN
  logic last;

  // Favour whoever did not win the previous handshake.
  assign conflict_pick = ~last;

  always_ff @(posedge clock) begin
    if (reset) begin
      last <= 1'b1;
    end else if (fire) begin
      last <= sel;
    end
  end
`else
  assign conflict_pick = 1'b0;
`endif

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req_valid == 2'b01): grant = 2'b01;
      (req_valid == 2'b10): grant = 2'b10;
      (req_valid == 2'b11):
        grant = conflict_pick ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign sel   = grant[1];
  assign drain = out_v & rsp_ready[out_owner];
  assign free  = ~out_v | drain;

  assign req_ready = grant & {2{free & ~reset}};
  assign fire      = |(req_valid & req_ready);

  ysyx_23060203_ALU u_alu (
    .a     (req_a[sel]),
    .b     (req_b[sel]),
    .funct (req_funct[sel]),
    .funcs (req_funcs[sel]),
    .val   (alu_val)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      out_v     <= 1'b0;
      out_owner <= 1'b0;
      out_data  <= 32'd0;
      out_tag   <= '0;
    end else if (fire) begin
      out_v     <= 1'b1;
      out_owner <= sel;
      out_data  <= alu_val;
      out_tag   <= req_tag[sel];
    end else if (drain) begin
      out_v <= 1'b0;
    end
  end

  assign rsp_valid = {out_v & out_owner, out_v & ~out_owner};
  assign rsp_data  = out_data;
  assign rsp_tag   = out_tag;

endmodule

// File: tb/tb_ysyx_23060203_alu_arb.sv
// Directed bench for the two-port ALU arbiter.
// Conflict expectations follow ALU_ARB_RR_EN when it is defined.
module tb_ysyx_23060203_alu_arb;
  import ysyx_23060203_alu_pkg::*;

  logic             clock;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_funct;
  logic [1:0]       req_funcs;
  logic [1:0][3:0]  req_tag;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_data;
  logic [3:0]       rsp_tag;

  int n_checks;
  int n_fail;

  ysyx_23060203_alu_arb #(.TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_funct (req_funct),
    .req_funcs (req_funcs),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] f,
                          input logic fs, input logic [3:0] t);
    req_a[p]     = a;
    req_b[p]     = b;
    req_funct[p] = f;
    req_funcs[p] = fs;
    req_tag[p]   = t;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_port(0, 32'd1, 32'd1, ALU_ADD, 1'b0, 4'h1);
    set_port(1, 32'd1, 32'd1, ALU_ADD, 1'b0, 4'h1);
    tick();
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 00", req_ready);
    end
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 00", rsp_valid);
    end
    n_checks++;
    if (rsp_data !== 32'd0 || rsp_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0/0",
               rsp_data, rsp_tag);
    end
    do_reset();
  endtask

  task automatic test_single();
    rsp_ready = 2'b11;
    set_port(0, 32'd5, 32'd3, ALU_ADD, 1'b1, 4'h2);
    req_valid = 2'b01;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd2 ||
        rsp_tag !== 4'h2) begin
      n_fail++;
      $display("FAIL single_rsp got %b/%h/%h want 01/2/2",
               rsp_valid, rsp_data, rsp_tag);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL single_drain got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    rsp_ready = 2'b11;
    set_port(0, 32'd1, 32'd1, ALU_ADD, 1'b0, 4'h1);
    set_port(1, 32'hFFFF_FFFF, 32'd1, ALU_LTS, 1'b0, 4'h3);
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL conflict_first got %b want 01", req_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd2 ||
        rsp_tag !== 4'h1) begin
      n_fail++;
      $display("FAIL conflict_rsp0 got %b/%h/%h want 01/2/1",
               rsp_valid, rsp_data, rsp_tag);
    end
`ifdef ALU_ARB_RR_EN
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL conflict_rr got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'd1 ||
        rsp_tag !== 4'h3) begin
      n_fail++;
      $display("FAIL conflict_rsp1 got %b/%h/%h want 10/1/3",
               rsp_valid, rsp_data, rsp_tag);
    end
`else
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL conflict_fixed got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd2) begin
      n_fail++;
      $display("FAIL conflict_fixed_rsp got %b/%h want 01/2",
               rsp_valid, rsp_data);
    end
`endif
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL conflict_drain got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b01;
    set_port(1, 32'h0000_00F0, 32'h0000_000F, ALU_OR, 1'b0, 4'h5);
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_accept got %b want 10", req_ready);
    end
    tick();
    set_port(0, 32'd7, 32'd8, ALU_ADD, 1'b0, 4'h6);
    req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 32'hFF ||
          rsp_tag !== 4'h5 || req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold%0d got %b/%h/%h/%b want 10/ff/5/00",
                 i, rsp_valid, rsp_data, rsp_tag, req_ready);
      end
      tick();
    end
    rsp_ready = 2'b11;
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd15 ||
        rsp_tag !== 4'h6) begin
      n_fail++;
      $display("FAIL bp_next got %b/%h/%h want 01/f/6",
               rsp_valid, rsp_data, rsp_tag);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_drain got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'h8000_0000;
    exp[1] = 32'hC000_0000;
    exp[2] = 32'hE000_0000;
    exp[3] = 32'hF000_0000;
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      set_port(0, 32'h8000_0000, 32'(i), ALU_SHR, 1'b1, 4'(i));
      #1;
      n_checks++;
      if (req_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL stream_ready%0d got %b want 01", i, req_ready);
      end
      tick();
      if (i == 3) req_valid = 2'b00;
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== exp[i] ||
          rsp_tag !== 4'(i)) begin
        n_fail++;
        $display("FAIL stream%0d got %b/%h/%h want 01/%h/%h",
                 i, rsp_valid, rsp_data, rsp_tag, exp[i], 4'(i));
      end
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL stream_drain got %b want 00", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 2'b00;
    set_port(0, 32'd1, 32'd2, ALU_ADD, 1'b0, 4'h7);
    set_port(1, 32'd9, 32'd9, ALU_XOR, 1'b0, 4'h8);
    req_valid = 2'b01;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd3) begin
      n_fail++;
      $display("FAIL rmid_load got %b/%h want 01/3",
               rsp_valid, rsp_data);
    end
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    reset = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL rmid_ready got %b want 00", req_ready);
    end
    tick();
    reset = 1'b0;
    n_checks++;
    if (rsp_valid !== 2'b00 || rsp_data !== 32'd0 ||
        rsp_tag !== 4'h0) begin
      n_fail++;
      $display("FAIL rmid_clear got %b/%h/%h want 00/0/0",
               rsp_valid, rsp_data, rsp_tag);
    end
    #1;
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL rmid_grant got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 32'd3 ||
        rsp_tag !== 4'h7) begin
      n_fail++;
      $display("FAIL rmid_rsp got %b/%h/%h want 01/3/7",
               rsp_valid, rsp_data, rsp_tag);
    end
    tick();
  endtask

  task automatic test_tag_echo();
    rsp_ready = 2'b11;
    set_port(1, 32'd1, 32'd2, ALU_LTU, 1'b0, 4'hF);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 32'd1 ||
        rsp_tag !== 4'hF) begin
      n_fail++;
      $display("FAIL tag_echo got %b/%h/%h want 10/1/f",
               rsp_valid, rsp_data, rsp_tag);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++;
      $display("FAIL tag_drain got %b want 00", rsp_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a = '0;
    req_b = '0;
    req_funct = '0;
    req_funcs = '0;
    req_tag = '0;
    test_reset();
    test_single();
    test_conflict();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_tag_echo();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
